// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the 5-stage pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REG_IDX_W       = 3;
    localparam int DEF_MEM_TIMEOUT = 64;

    // All-zero word decodes as a never-taken branch, i.e. a NOP.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : RAW comparators between ID sources and EX/MEM/WB producers.
//               Macro PIPE_FORWARDING_EN restricts stalls to load-use only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_id_sr1,
    input  logic [REG_IDX_W-1:0] i_id_sr2,
    input  logic                 i_id_sr1_used,
    input  logic                 i_id_sr2_used,
    input  logic                 i_ex_valid,
    input  logic                 i_ex_wr_en,
    input  logic                 i_ex_is_load,
    input  logic [REG_IDX_W-1:0] i_ex_dr,
    input  logic                 i_mem_valid,
    input  logic                 i_mem_wr_en,
    input  logic [REG_IDX_W-1:0] i_mem_dr,
    input  logic                 i_wb_valid,
    input  logic                 i_wb_wr_en,
    input  logic [REG_IDX_W-1:0] i_wb_dr,
    output logic                 o_hazard
);

    logic w_ex_match;
    logic w_mem_match;
    logic w_wb_match;

    assign w_ex_match  = i_ex_valid & i_ex_wr_en &
                         ((i_id_sr1_used & (i_id_sr1 == i_ex_dr)) |
                          (i_id_sr2_used & (i_id_sr2 == i_ex_dr)));
    assign w_mem_match = i_mem_valid & i_mem_wr_en &
                         ((i_id_sr1_used & (i_id_sr1 == i_mem_dr)) |
                          (i_id_sr2_used & (i_id_sr2 == i_mem_dr)));
    assign w_wb_match  = i_wb_valid & i_wb_wr_en &
                         ((i_id_sr1_used & (i_id_sr1 == i_wb_dr)) |
                          (i_id_sr2_used & (i_id_sr2 == i_wb_dr)));

`ifdef PIPE_FORWARDING_EN
    // Bypass covers every producer except a load still in EX.
    logic w_unused;
    assign w_unused = w_mem_match ^ w_wb_match;
    assign o_hazard = w_ex_match & i_ex_is_load;
`else
    logic w_unused;
    assign w_unused = i_ex_is_load;
    assign o_hazard = w_ex_match | w_mem_match | w_wb_match;
`endif

endmodule : hazard_detect

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush/freeze controller with performance counters.
//               Macro PIPE_FORWARDING_EN selects load-use-only stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_sr1,
    input  logic [REG_IDX_W-1:0] id_sr2,
    input  logic                 id_sr1_used,
    input  logic                 id_sr2_used,
    input  logic                 ex_valid,
    input  logic                 ex_wr_en,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_dr,
    input  logic                 mem_valid,
    input  logic                 mem_wr_en,
    input  logic [REG_IDX_W-1:0] mem_dr,
    input  logic                 wb_valid,
    input  logic                 wb_wr_en,
    input  logic [REG_IDX_W-1:0] wb_dr,
    input  logic                 br_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    input  logic                 perf_clr,
    output logic                 PC_WR_EN,
    output logic                 FE_LATCH_WR,
    output logic                 ID_LATCH_WR,
    output logic                 EX_LATCH_WR,
    output logic                 MEM_LATCH_WR,
    output logic                 fe_flush,
    output logic                 id_flush,
    output logic                 ex_bubble,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     perf_stall,
    output logic [CNT_W-1:0]     perf_flush
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_perf_stall;
    logic [CNT_W-1:0]  r_perf_flush;

    logic w_hazard;
    logic w_freeze;
    logic w_redirect;
    logic w_stall;
    logic w_wait_tick;

    hazard_detect u_hazard_detect (
        .i_id_sr1      (id_sr1),
        .i_id_sr2      (id_sr2),
        .i_id_sr1_used (id_sr1_used),
        .i_id_sr2_used (id_sr2_used),
        .i_ex_valid    (ex_valid),
        .i_ex_wr_en    (ex_wr_en),
        .i_ex_is_load  (ex_is_load),
        .i_ex_dr       (ex_dr),
        .i_mem_valid   (mem_valid),
        .i_mem_wr_en   (mem_wr_en),
        .i_mem_dr      (mem_dr),
        .i_wb_valid    (wb_valid),
        .i_wb_wr_en    (wb_wr_en),
        .i_wb_dr       (wb_dr),
        .o_hazard      (w_hazard)
    );

    assign w_freeze    = mem_valid & dmem_req & ~dmem_ready;
    assign w_redirect  = ex_valid & br_taken & ~w_freeze;
    assign w_stall     = w_hazard & ~w_freeze & ~w_redirect;
    assign w_wait_tick = (r_state == ST_MEM_WAIT) & w_freeze;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The cycle dmem_ready rises is already a RUN cycle, so outputs depend
    // only on the live freeze condition rather than on r_state.
    always_comb begin
        w_state_nxt  = w_freeze ? ST_MEM_WAIT : ST_RUN;
        PC_WR_EN     = 1'b1;
        FE_LATCH_WR  = 1'b1;
        ID_LATCH_WR  = 1'b1;
        EX_LATCH_WR  = 1'b1;
        MEM_LATCH_WR = 1'b1;
        fe_flush     = 1'b0;
        id_flush     = 1'b0;
        ex_bubble    = 1'b0;
        if (reset) begin
            PC_WR_EN     = 1'b0;
            FE_LATCH_WR  = 1'b0;
            ID_LATCH_WR  = 1'b0;
            EX_LATCH_WR  = 1'b0;
            MEM_LATCH_WR = 1'b0;
            fe_flush     = 1'b1;
            id_flush     = 1'b1;
        end else if (w_freeze) begin
            PC_WR_EN     = 1'b0;
            FE_LATCH_WR  = 1'b0;
            ID_LATCH_WR  = 1'b0;
            EX_LATCH_WR  = 1'b0;
            MEM_LATCH_WR = 1'b0;
        end else if (w_redirect) begin
            fe_flush     = 1'b1;
            id_flush     = 1'b1;
        end else if (w_stall) begin
            PC_WR_EN     = 1'b0;
            FE_LATCH_WR  = 1'b0;
            ID_LATCH_WR  = 1'b0;
            ex_bubble    = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else if (w_wait_tick) begin
            if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                r_mem_err <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else if (perf_clr) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (w_redirect && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 1'b1;
            end
        end
    end

    assign mem_err    = r_mem_err;
    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;

endmodule : pipeline_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [2:0]  id_sr1, id_sr2, ex_dr, mem_dr, wb_dr;
    logic        id_sr1_used, id_sr2_used;
    logic        ex_valid, ex_wr_en, ex_is_load;
    logic        mem_valid, mem_wr_en, wb_valid, wb_wr_en;
    logic        br_taken, dmem_req, dmem_ready, perf_clr;
    logic        PC_WR_EN, FE_LATCH_WR, ID_LATCH_WR, EX_LATCH_WR, MEM_LATCH_WR;
    logic        fe_flush, id_flush, ex_bubble, mem_err;
    logic [15:0] perf_stall, perf_flush;
    logic [7:0]  w_ctrl;

    int n_pass  = 0;
    int n_total = 0;

    // {PC, FE, ID, EX, MEM, fe_flush, id_flush, ex_bubble}
    localparam logic [7:0] C_RESET  = 8'h06;
    localparam logic [7:0] C_NORMAL = 8'hF8;
    localparam logic [7:0] C_STALL  = 8'h19;
    localparam logic [7:0] C_REDIR  = 8'hFE;
    localparam logic [7:0] C_FREEZE = 8'h00;

`ifdef PIPE_FORWARDING_EN
    localparam logic [7:0] C_NONLOAD = C_NORMAL;
    localparam int         N_NONLOAD = 0;
`else
    localparam logic [7:0] C_NONLOAD = C_STALL;
    localparam int         N_NONLOAD = 3;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .id_sr1       (id_sr1),
        .id_sr2       (id_sr2),
        .id_sr1_used  (id_sr1_used),
        .id_sr2_used  (id_sr2_used),
        .ex_valid     (ex_valid),
        .ex_wr_en     (ex_wr_en),
        .ex_is_load   (ex_is_load),
        .ex_dr        (ex_dr),
        .mem_valid    (mem_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_dr       (mem_dr),
        .wb_valid     (wb_valid),
        .wb_wr_en     (wb_wr_en),
        .wb_dr        (wb_dr),
        .br_taken     (br_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .perf_clr     (perf_clr),
        .PC_WR_EN     (PC_WR_EN),
        .FE_LATCH_WR  (FE_LATCH_WR),
        .ID_LATCH_WR  (ID_LATCH_WR),
        .EX_LATCH_WR  (EX_LATCH_WR),
        .MEM_LATCH_WR (MEM_LATCH_WR),
        .fe_flush     (fe_flush),
        .id_flush     (id_flush),
        .ex_bubble    (ex_bubble),
        .mem_err      (mem_err),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
    );

    assign w_ctrl = {PC_WR_EN, FE_LATCH_WR, ID_LATCH_WR, EX_LATCH_WR,
                     MEM_LATCH_WR, fe_flush, id_flush, ex_bubble};

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle();
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_sr1_used = 1'b0; id_sr2_used = 1'b0;
        ex_valid = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_dr = 3'd0;
        mem_valid = 1'b0; mem_wr_en = 1'b0; mem_dr = 3'd0;
        wb_valid = 1'b0; wb_wr_en = 1'b0; wb_dr = 3'd0;
        br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic clear_perf();
        idle();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
    endtask

    initial begin
        idle();
        step();
        step();
        check_eq("reset_ctrl", 32'(w_ctrl), 32'(C_RESET));
        check_eq("reset_stall", 32'(perf_stall), 32'd0);
        check_eq("reset_flush", 32'(perf_flush), 32'd0);
        check_eq("reset_err", 32'(mem_err), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("idle_ctrl", 32'(w_ctrl), 32'(C_NORMAL));

        // Load-use: LDR R2 in EX, consumer reads R2 as sr1
        step();
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_dr = 3'd2;
        id_sr1 = 3'd2; id_sr1_used = 1'b1;
        #1;
        check_eq("lu_ctrl", 32'(w_ctrl), 32'(C_STALL));
        step();
        check_eq("lu_cnt", 32'(perf_stall), 32'd1);
        ex_valid = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
        mem_valid = 1'b1; mem_wr_en = 1'b1; mem_dr = 3'd2;
        #1;
        check_eq("lu_after", 32'(w_ctrl), 32'(C_NONLOAD));

        // Non-load producer R3 drains EX -> MEM -> WB
        clear_perf();
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_dr = 3'd3;
        id_sr2 = 3'd3; id_sr2_used = 1'b1;
        #1;
        check_eq("nl_ex", 32'(w_ctrl), 32'(C_NONLOAD));
        step();
        ex_valid = 1'b0; ex_wr_en = 1'b0;
        mem_valid = 1'b1; mem_wr_en = 1'b1; mem_dr = 3'd3;
        #1;
        check_eq("nl_mem", 32'(w_ctrl), 32'(C_NONLOAD));
        step();
        mem_valid = 1'b0; mem_wr_en = 1'b0;
        wb_valid = 1'b1; wb_wr_en = 1'b1; wb_dr = 3'd3;
        #1;
        check_eq("nl_wb", 32'(w_ctrl), 32'(C_NONLOAD));
        step();
        wb_valid = 1'b0; wb_wr_en = 1'b0;
        #1;
        check_eq("nl_done", 32'(w_ctrl), 32'(C_NORMAL));
        check_eq("nl_cnt", 32'(perf_stall), 32'(N_NONLOAD));

        // Taken branch with a simultaneous load-use hazard in ID
        clear_perf();
        ex_valid = 1'b1; br_taken = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1;
        ex_dr = 3'd1; id_sr1 = 3'd1; id_sr1_used = 1'b1;
        #1;
        check_eq("br_ctrl", 32'(w_ctrl), 32'(C_REDIR));
        step();
        idle();
        check_eq("br_flush_cnt", 32'(perf_flush), 32'd1);
        check_eq("br_stall_cnt", 32'(perf_stall), 32'd0);

        // Request completing in the same cycle causes no wait
        mem_valid = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        check_eq("mem_ready_now", 32'(w_ctrl), 32'(C_NORMAL));

        // Timeout: 1 RUN freeze cycle then 4 MEM_WAIT cycles
        step();
        dmem_ready = 1'b0;
        #1;
        check_eq("to_freeze", 32'(w_ctrl), 32'(C_FREEZE));
        for (int i = 0; i < 4; i++) step();
        check_eq("to_err_early", 32'(mem_err), 32'd0);
        step();
        check_eq("to_err_set", 32'(mem_err), 32'd1);
        dmem_ready = 1'b1;
        #1;
        check_eq("to_release", 32'(w_ctrl), 32'(C_NORMAL));
        step();
        check_eq("to_sticky", 32'(mem_err), 32'd1);
        dmem_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check_eq("rst_err", 32'(mem_err), 32'd0);
        check_eq("rst_flush_cnt", 32'(perf_flush), 32'd0);
        check_eq("rst_ctrl", 32'(w_ctrl), 32'(C_RESET));
        step();
        reset = 1'b0;
        // State must be RUN again: timeout needs a fresh 1 + 4 cycles
        for (int i = 0; i < 4; i++) step();
        check_eq("rst_state_run", 32'(mem_err), 32'd0);
        step();
        check_eq("rst_err_again", 32'(mem_err), 32'd1);

        // Memory wait with a branch pending in EX
        dmem_ready = 1'b1;
        step();
        clear_perf();
        mem_valid = 1'b1; dmem_req = 1'b1; ex_valid = 1'b1; br_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("mw_freeze%0d", i), 32'(w_ctrl), 32'(C_FREEZE));
            step();
        end
        check_eq("mw_noflush", 32'(perf_flush), 32'd0);
        dmem_ready = 1'b1;
        #1;
        check_eq("mw_redirect", 32'(w_ctrl), 32'(C_REDIR));
        step();
        check_eq("mw_flush_cnt", 32'(perf_flush), 32'd1);

        // Saturation then clear with a stall present
        clear_perf();
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_dr = 3'd5;
        id_sr2 = 3'd5; id_sr2_used = 1'b1;
        for (int i = 0; i < 65539; i++) step();
        check_eq("sat_stall", 32'(perf_stall), 32'h0000_FFFF);
        perf_clr = 1'b1;
        step();
        check_eq("sat_clr", 32'(perf_stall), 32'd0);
        check_eq("sat_flush0", 32'(perf_flush), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 16-bit 5-stage pipeline (FE, ID, EX, MEM, WB). Each cycle it decides which pipeline latches write, which stages take a bubble and when the PC updates. It resolves RAW data hazards, taken-branch redirects and multi-cycle data-memory waits, and keeps saturating performance counters. It drives the `PC_WR_EN` and `FE_LATCH_WR` enables of the fetch stage and the latch enables of every downstream stage.

## Interface
- `MEM_TIMEOUT`, default 64: number of MEM_WAIT cycles after which `mem_err` is raised.
- `CNT_W`, default 16: width of the performance counters.
- `CLOCK_50` in 1: the single clock for all state.
- `reset` in 1: asynchronous, active-high reset.
- `id_sr1`, `id_sr2` in 3 each: source register indices of the instruction in ID.
- `id_sr1_used`, `id_sr2_used` in 1 each: the corresponding source is actually read.
- `ex_valid`, `ex_wr_en`, `ex_is_load` in 1 each: qualifiers for the instruction in EX.
- `ex_dr` in 3: destination register of the instruction in EX.
- `mem_valid`, `mem_wr_en` in 1 each: qualifiers for the instruction in MEM.
- `mem_dr` in 3: destination register of the instruction in MEM.
- `wb_valid`, `wb_wr_en` in 1 each: qualifiers for the instruction in WB.
- `wb_dr` in 3: destination register of the instruction in WB.
- `br_taken` in 1: branch resolved taken in EX. Qualified by `ex_valid`.
- `dmem_req`, `dmem_ready` in 1 each: MEM-stage data-memory request and its completion.
- `perf_clr` in 1: synchronous clear of both performance counters.
- `PC_WR_EN`, `FE_LATCH_WR`, `ID_LATCH_WR`, `EX_LATCH_WR`, `MEM_LATCH_WR` out 1 each: latch write enables.
- `fe_flush`, `id_flush` out 1 each: load a NOP into the FE/ID and ID/EX latches respectively.
- `ex_bubble` out 1: insert a NOP into EX while ID holds.
- `mem_err` out 1: sticky memory-timeout flag.
- `perf_stall`, `perf_flush` out `CNT_W` each: saturating counts of hazard-stall cycles and redirects.

## Operation
- State machine with states RUN and MEM_WAIT. The state register is the only state besides the counters.
- **Freeze** has top priority. Condition: `mem_valid & dmem_req & !dmem_ready`.
  - All `*_LATCH_WR` = 0 and `PC_WR_EN` = 0.
  - No flush and no bubble.
  - Transition RUN -> MEM_WAIT.
- MEM_WAIT -> RUN in the cycle `dmem_ready` = 1. That cycle is evaluated as RUN.
- A wait counter increments every MEM_WAIT cycle. When it reaches `MEM_TIMEOUT`, `mem_err` sets and stays set until `reset`. The freeze continues regardless.
- **Redirect** is second priority. Condition: `ex_valid & br_taken`, no freeze.
  - `PC_WR_EN` = 1 to load the target.
  - `fe_flush` = 1 and `id_flush` = 1, squashing the two younger instructions.
  - All latch enables = 1.
  - The data-hazard check is ignored.
  - `perf_flush` +1.
- **Data hazard** is third priority. A source matches a producer when the source is used, the producer is valid with `wr_en` = 1, and the indices are equal.
  - With `PIPE_FORWARDING_EN`: hazard only if the EX producer matches and `ex_is_load` = 1 (load-use).
  - Without `PIPE_FORWARDING_EN`: hazard if any EX, MEM or WB producer matches.
  - Response: `PC_WR_EN` = 0, `FE_LATCH_WR` = 0, `ID_LATCH_WR` = 0, `ex_bubble` = 1; `EX_LATCH_WR` and `MEM_LATCH_WR` = 1; `perf_stall` +1.
- **Otherwise:** all enables = 1, with no flush and no bubble.
- Counters saturate at all-ones. `perf_clr` has priority over an increment in the same cycle.
- Register index arithmetic is unsigned 3-bit equality only. Register R0 is not special.

## Timing
- All control outputs are combinational from the current state and the current-cycle inputs, with zero latency. The state and counters update on the rising edge of `CLOCK_50`.
- While `reset` = 1:
  - State = RUN; wait counter, `perf_stall` and `perf_flush` = 0; `mem_err` = 0.
  - All `*_LATCH_WR` = 0 and `PC_WR_EN` = 0; `fe_flush` = `id_flush` = 1; `ex_bubble` = 0.
- Reset mid-MEM_WAIT returns the block to RUN immediately and asynchronously.
- A load-use stall lasts exactly 1 cycle with forwarding. Without forwarding it lasts up to 3 cycles while the producer drains.
- Freeze and branch in the same cycle: freeze wins. The EX latch is held, so `br_taken` re-presents and is redirected in the first cycle after `dmem_ready`.
- `dmem_ready` in the same cycle as a new request completes that request with no wait.

## Configuration
- `PIPE_FORWARDING_EN` defined: EX/MEM-to-EX bypass exists in the datapath, so only load-use hazards stall.
- `PIPE_FORWARDING_EN` undefined: no bypass exists, so any pending writer in EX, MEM or WB stalls ID.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MEM_WAIT);
  - `REG_IDX_W` = 3;
  - the default `MEM_TIMEOUT`;
  - the NOP instruction constant used by the flush logic.
- Sub-module `hazard_detect` is combinational. It contains the source/producer comparators and outputs a single `hazard` bit, with the `PIPE_FORWARDING_EN` selection inside it.

## Test plan
- **Load-use stall.** With forwarding: LDR R2 in EX (`ex_is_load` = 1, `ex_dr` = 2), ADD in ID with `id_sr1` = 2 -> exactly 1 cycle of `PC_WR_EN` = 0 and `ex_bubble` = 1; `perf_stall` = 1.
- **Non-load producer.** Without forwarding: ADD R3 in EX, consumer in ID with `id_sr2` = 3 -> 3 stall cycles as the producer moves EX -> MEM -> WB. With forwarding the same stimulus gives 0 stalls.
- **Taken branch.** `br_taken` = 1 with `ex_valid` = 1 -> `fe_flush` = `id_flush` = 1 and `PC_WR_EN` = 1 for one cycle; `perf_flush` = 1. A simultaneous hazard in ID produces no stall.
- **Memory wait.** `dmem_req` = 1 with `dmem_ready` = 0 for 5 cycles -> all enables 0 for 5 cycles. Branch pending in EX -> redirect occurs on the cycle `dmem_ready` = 1.
- **Timeout.** `MEM_TIMEOUT` = 4 with `dmem_ready` held 0 -> `mem_err` = 1 after 4 MEM_WAIT cycles and stays 1 after `dmem_ready`. Asserting `reset` clears it, returns state to RUN and zeros the counters.
- **Saturation and clear.** Force 2^16 + 3 stall cycles -> `perf_stall` = 0xFFFF. `perf_clr` together with a stall -> 0.
